// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: program counter, ROM fetch and instruction register feeding decode over valid/ready.
module instr_fetch_unit #(
  parameter int ADDR_W = 8,
  parameter int INSTR_W = 29,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [4:0]         opcode,
  output logic [3:0]         field_a,
  output logic [3:0]         field_b,
  output logic [15:0]        imm
);
  typedef enum logic [1:0] {BOOT, RUN, HOLD, IDLE} state_e;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, ipc_q, ipc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic valid_q, valid_d, xfer, cap, redir, load;
  always_comb begin
    xfer = valid_q && instr_ready;
    redir = state_q != BOOT && redirect_valid;
    cap = state_q != BOOT && fetch_en && (!valid_q || xfer);
    load = cap && !redir;
    pc_d = redir ? redirect_pc : cap ? pc_q + ADDR_W'(1) : pc_q;
    valid_d = !redir && (cap || (valid_q && !xfer));
    instr_d = load ? rom_data : instr_q;
    ipc_d = load ? pc_q : ipc_q;
    // a live word that was neither replaced nor squashed is being stalled by decode
    state_d = state_q == BOOT ? RUN : (valid_d && !load) ? HOLD : fetch_en ? RUN : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q <= RESET_PC;
      ipc_q <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ipc_q <= ipc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end
  assign rom_addr = pc_q;
  assign instr_valid = valid_q;
  assign instr_out = instr_q;
  assign instr_pc = ipc_q;
  assign opcode = instr_q[28:24];
  assign field_a = instr_q[23:20];
  assign field_b = instr_q[19:16];
  assign imm = instr_q[15:0];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: table-driven fetch vectors plus a scoreboard of instructions handed to decode.
module tb_instr_fetch_unit;
  logic clk = 0, rst_n = 0, fetch_en = 0, redirect_valid = 0, instr_ready = 0, instr_valid;
  logic [7:0] rom_addr, redirect_pc = 0, instr_pc;
  logic [28:0] rom_data, instr_out;
  logic [4:0] opcode;
  logic [3:0] field_a, field_b;
  logic [15:0] imm;
  logic [28:0] rom [256];
  int checks = 0, errors = 0;
  logic exp_v = 0;
  logic [7:0] exp_ipc = 0;
  logic [7:0] sb [$];

  typedef struct {
    logic fe, rdy, rv;
    logic [7:0] rpc;
    logic v;
    logic [7:0] ipc, addr;
  } vec_t;
  vec_t vecs [$];

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_out(instr_out), .instr_pc(instr_pc), .opcode(opcode),
    .field_a(field_a), .field_b(field_b), .imm(imm)
  );

  assign rom_data = rom[rom_addr];
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_word(input logic [7:0] p);
    logic [28:0] w;
    w = rom[p];
    chk("instr_pc", 32'(instr_pc), 32'(p));
    chk("instr_out", 32'(instr_out), 32'(w));
    chk("opcode", 32'(opcode), 32'(w[28:24]));
    chk("field_a", 32'(field_a), 32'(w[23:20]));
    chk("field_b", 32'(field_b), 32'(w[19:16]));
    chk("imm", 32'(imm), 32'(w[15:0]));
  endtask

  task automatic step(input logic fe, input logic rdy, input logic rv, input logic [7:0] rpc);
    logic [7:0] p;
    fetch_en = fe;
    instr_ready = rdy;
    redirect_valid = rv;
    redirect_pc = rpc;
    if (exp_v && rdy) sb.push_back(exp_ipc);
    if (instr_valid && instr_ready) begin
      if (sb.size() == 0) chk("sb_unexpected_xfer", 32'(instr_pc), 32'hFFFF_FFFF);
      else begin
        p = sb.pop_front();
        chk("sb_pc", 32'(instr_pc), 32'(p));
        chk("sb_word", 32'(instr_out), 32'(rom[p]));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic vec_t mk(logic fe, logic rdy, logic rv, logic [7:0] rpc, logic v, logic [7:0] ipc, logic [7:0] addr);
    vec_t r;
    r.fe = fe; r.rdy = rdy; r.rv = rv; r.rpc = rpc; r.v = v; r.ipc = ipc; r.addr = addr;
    return r;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = {5'(i * 3), 4'(i >> 4), 4'(i), 8'(i), 8'(~i)};
    rom[0] = 29'h01000001;
    rom[1] = 29'h15000007;
    vecs.push_back(mk(1, 1, 0, 8'h00, 1, 8'h02, 8'h03));
    vecs.push_back(mk(1, 1, 0, 8'h00, 1, 8'h03, 8'h04));
    vecs.push_back(mk(1, 1, 0, 8'h00, 1, 8'h04, 8'h05));
    vecs.push_back(mk(1, 0, 0, 8'h00, 1, 8'h04, 8'h05));
    vecs.push_back(mk(1, 0, 0, 8'h00, 1, 8'h04, 8'h05));
    vecs.push_back(mk(1, 0, 0, 8'h00, 1, 8'h04, 8'h05));
    vecs.push_back(mk(1, 1, 0, 8'h00, 1, 8'h05, 8'h06));
    vecs.push_back(mk(1, 1, 1, 8'h60, 0, 8'h00, 8'h60));
    vecs.push_back(mk(1, 1, 0, 8'h00, 1, 8'h60, 8'h61));
    vecs.push_back(mk(1, 1, 0, 8'h00, 1, 8'h61, 8'h62));
    vecs.push_back(mk(1, 1, 0, 8'h00, 1, 8'h62, 8'h63));
    vecs.push_back(mk(1, 0, 1, 8'h5E, 0, 8'h00, 8'h5E));
    vecs.push_back(mk(1, 0, 0, 8'h00, 1, 8'h5E, 8'h5F));
    vecs.push_back(mk(1, 1, 0, 8'h00, 1, 8'h5F, 8'h60));
    vecs.push_back(mk(1, 1, 1, 8'hFE, 0, 8'h00, 8'hFE));
    vecs.push_back(mk(1, 1, 0, 8'h00, 1, 8'hFE, 8'hFF));
    vecs.push_back(mk(1, 1, 0, 8'h00, 1, 8'hFF, 8'h00));
    vecs.push_back(mk(1, 1, 0, 8'h00, 1, 8'h00, 8'h01));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 8'h01));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 8'h01));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 8'h01));
    vecs.push_back(mk(1, 0, 0, 8'h00, 1, 8'h01, 8'h02));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 8'h01, 8'h02));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 8'h02));
    vecs.push_back(mk(1, 1, 0, 8'h00, 1, 8'h02, 8'h03));
    vecs.push_back(mk(0, 0, 1, 8'h10, 0, 8'h00, 8'h10));
    vecs.push_back(mk(1, 1, 0, 8'h00, 1, 8'h10, 8'h11));
    vecs.push_back(mk(1, 0, 0, 8'h00, 1, 8'h10, 8'h11));

    #12;
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_out", 32'(instr_out), 0);
    chk("rst_ipc", 32'(instr_pc), 0);
    chk("rst_addr", 32'(rom_addr), 0);
    chk("rst_opcode", 32'(opcode), 0);
    @(negedge clk);
    rst_n = 1;
    step(1, 1, 0, 0);
    chk("boot_valid", 32'(instr_valid), 0);
    chk("boot_addr", 32'(rom_addr), 0);
    step(1, 1, 0, 0);
    exp_v = 1; exp_ipc = 0;
    chk("first_valid", 32'(instr_valid), 1);
    chk("first_out", 32'(instr_out), 32'h01000001);
    chk("first_ipc", 32'(instr_pc), 0);
    chk("first_opcode", 32'(opcode), 32'h01);
    chk("first_imm", 32'(imm), 32'h0001);
    step(1, 1, 0, 0);
    exp_ipc = 1;
    chk("second_out", 32'(instr_out), 32'h15000007);
    chk("second_opcode", 32'(opcode), 32'h15);
    chk("second_imm", 32'(imm), 32'h0007);
    chk("second_addr", 32'(rom_addr), 2);

    foreach (vecs[i]) begin
      step(vecs[i].fe, vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
      chk($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vecs[i].v));
      chk($sformatf("v%0d_addr", i), 32'(rom_addr), 32'(vecs[i].addr));
      if (vecs[i].v) chk_word(vecs[i].ipc);
      exp_v = vecs[i].v;
      exp_ipc = vecs[i].ipc;
    end

    #2 rst_n = 0;
    #1;
    exp_v = 0;
    chk("arst_valid", 32'(instr_valid), 0);
    chk("arst_addr", 32'(rom_addr), 0);
    chk("arst_out", 32'(instr_out), 0);
    chk("arst_ipc", 32'(instr_pc), 0);
    @(negedge clk);
    rst_n = 1;
    step(1, 1, 1, 8'h40);
    chk("boot_redirect_ignored", 32'(rom_addr), 0);
    chk("boot2_valid", 32'(instr_valid), 0);
    step(1, 0, 0, 0);
    exp_v = 1; exp_ipc = 0;
    chk("refetch_valid", 32'(instr_valid), 1);
    chk("refetch_out", 32'(instr_out), 32'h01000001);
    chk("refetch_addr", 32'(rom_addr), 1);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage that drives the instruction ROM's 8-bit address input and consumes its 29-bit combinational instruction word.
- Holds the program counter, registers each fetched word with its PC into an instruction register, and splits it into opcode, register fields and immediate.
- Presents the result to decode through a valid/ready handshake.
- Accepts PC redirects from execute for jumps and branches, and squashes the in-flight instruction on redirect.

Parameters:
- ADDR_W, 8, PC and ROM address width.
- INSTR_W, 29, instruction word width.
- RESET_PC, 0, PC loaded on reset.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_en  in  1  fetch enable; low freezes PC advance.
- rom_addr  out  ADDR_W  ROM address; equals pc combinationally.
- rom_data  in  INSTR_W  ROM instruction word; combinational from rom_addr, same cycle.
- redirect_valid  in  1  execute requests PC change.
- redirect_pc  in  ADDR_W  redirect target.
- instr_valid  out  1  instruction register holds a live instruction.
- instr_ready  in  1  decode accepts this cycle.
- instr_out  out  INSTR_W  registered instruction word.
- instr_pc  out  ADDR_W  PC of instr_out.
- opcode  out  5  instr_out[28:24].
- field_a  out  4  instr_out[23:20].
- field_b  out  4  instr_out[19:16].
- imm  out  16  instr_out[15:0].

Behaviour:
- Reset (async, rst_n low):
  - pc=RESET_PC, instr_valid=0, instr_out=0, instr_pc=0.
  - state=BOOT; all decode fields therefore 0.
- States:
  - BOOT: one cycle after reset release with no capture, then go to RUN.
  - RUN: normal fetch.
  - HOLD: instr_valid=1 and instr_ready=0.
  - IDLE: fetch_en=0 and instruction register empty or consumed.
- Transfer: decode consumes when instr_valid && instr_ready at the clock edge.
- Capture condition, per cycle in RUN/HOLD/IDLE: fetch_en=1 and (instr_valid=0 or transfer).
  - On capture: instr_out<=rom_data, instr_pc<=pc, instr_valid<=1, pc<=pc+1.
  - Sustained throughput is 1 instruction/cycle when instr_ready=1.
  - Latency from pc to instr_out is 1 cycle.
- No capture and transfer: instr_valid<=0; pc unchanged.
- No capture, no transfer: everything holds (HOLD); instr_out must stay stable while valid && !ready.
- fetch_en=0: no capture and pc frozen. A held instruction remains valid until consumed, then the state goes to IDLE. fetch_en=1 returns to RUN.
- Redirect (highest priority, any state except BOOT):
  - pc<=redirect_pc and instr_valid<=0 (squash), regardless of instr_ready or fetch_en.
  - The instruction at the target is captured the following cycle, giving a 1-cycle bubble.
  - A redirect in BOOT is ignored.
- Simultaneous redirect and transfer: the transfer is counted as accepted by decode; the register still clears and pc takes redirect_pc.
- Wrap-around: pc=255 increments to 0 (modulo 2^ADDR_W); no flag is raised.
- Reset mid-operation: immediate return to reset values regardless of handshake; the pending instruction is lost.
- rom_addr is purely combinational from the pc register and has no dependency on rom_data, so no comb loop exists.
- Decode fields are pure slices of instr_out, not separately registered.

Test Plan:
- Reset then fetch_en=1, instr_ready=1, ROM[0]=0x01000001, ROM[1]=0x15000007:
  - cycle 1 after BOOT: rom_addr=0.
  - next edge: instr_out=0x01000001, instr_pc=0, opcode=0x01, imm=0x0001.
  - following edge: instr_out=0x15000007, opcode=0x15, imm=0x0007, pc=2.
- Backpressure: hold instr_ready=0 for 3 cycles with valid=1 at instr_pc=4:
  - instr_out and instr_pc stay constant and pc stays 5.
  - raising ready gives instr_pc=5 on the next edge.
- Redirect to 0x5E while instr_pc=0x62 is valid and ready=0:
  - next edge: instr_valid=0, pc=0x5E.
  - edge after: instr_pc=0x5E valid, with instr_out equal to ROM[0x5E].
- Wrap: run from pc=0xFE; the sequence of instr_pc is 0xFE, 0xFF, 0x00, with no bubble.
- fetch_en drop with ready=1: the current instruction is consumed, then valid=0 and pc frozen; fetch_en=1 resumes at the frozen pc.
- Assert rst_n=0 asynchronously mid-HOLD: instr_valid drops immediately, pc=0; after release, BOOT then fetch ROM[0].
